// File: rtl/tetris_pkg.sv
// Shared playfield definitions.
// Holds the board geometry, the cell colour and row types, index types sized
// to the board, and the lock/clear FSM state encoding.
package tetris_pkg;

  localparam int unsigned BOARD_W   = 10;
  localparam int unsigned BOARD_H   = 20;
  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned COL_IDX_W = $clog2(BOARD_W);
  localparam int unsigned ROW_IDX_W = $clog2(BOARD_H);

  // Colour 0 is an empty cell.
  typedef logic [COLOUR_W-1:0]  colour_t;
  typedef colour_t [BOARD_W-1:0] row_t;
  typedef logic [COL_IDX_W-1:0] col_idx_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWrite,
    StScan,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/board_row_full.sv
// Combinational full-row detector.
// Ports:
//   row  - one playfield row (BOARD_W cells)
//   full - 1 when every cell in the row is non-empty
module board_row_full
  import tetris_pkg::*;
(
  input  row_t row,
  output logic full
);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < BOARD_W; i++) begin
      if (row[i] == '0) begin
        full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/playfield_lock_clear.sv
// Playfield colour array with piece lock, full-row collapse and read ports.
// A lock writes the four piece cells, then scans from the bottom row upward,
// collapsing each full row and rechecking the same row index afterwards.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   clear_req              - empty the whole board (20 cycles)
//   board_rdy              - idle, able to accept clear_req / lock_start
//   lock_start             - lock request with lock_x0..3, lock_y0..3, lock_colour
//   lock_done              - one-cycle completion pulse
//   lines_cleared          - rows removed by the last lock, held until the next one
//   query_x/y, query_occupied        - collision query (off-board reads as occupied)
//   vga_x/y, vga_colour, vga_occupied - display read (off-board reads as empty)
module playfield_lock_clear
  import tetris_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_req,
  output logic                board_rdy,
  input  logic                lock_start,
  input  logic [5:0]          lock_x0,
  input  logic [5:0]          lock_x1,
  input  logic [5:0]          lock_x2,
  input  logic [5:0]          lock_x3,
  input  logic [5:0]          lock_y0,
  input  logic [5:0]          lock_y1,
  input  logic [5:0]          lock_y2,
  input  logic [5:0]          lock_y3,
  input  logic [COLOUR_W-1:0] lock_colour,
  output logic                lock_done,
  output logic [2:0]          lines_cleared,
  input  logic [3:0]          query_x,
  input  logic [4:0]          query_y,
  output logic                query_occupied,
  input  logic [3:0]          vga_x,
  input  logic [4:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_occupied
);

  localparam logic [5:0] LockXLim = 6'(BOARD_W);
  localparam logic [5:0] LockYLim = 6'(BOARD_H);
  localparam col_idx_t   ColLim   = col_idx_t'(BOARD_W);
  localparam row_idx_t   RowLim   = row_idx_t'(BOARD_H);
  localparam row_idx_t   LastRow  = row_idx_t'(BOARD_H - 1);
  localparam row_idx_t   RowOne   = row_idx_t'(1);
  localparam logic [2:0] MaxLines = 3'd4;

  state_e     state_q, state_d;
  row_t       board_q [BOARD_H];
  row_t       board_d [BOARD_H];
  row_idx_t   row_q, row_d;
  row_idx_t   k_q, k_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] lines_q, lines_d;
  logic [2:0] lines_cleared_q, lines_cleared_d;

  logic [5:0] lat_x_q [4];
  logic [5:0] lat_y_q [4];
  colour_t    lat_colour_q;
  logic [5:0] lock_x [4];
  logic [5:0] lock_y [4];
  logic       lock_accept;

  logic       cell_ok;
  col_idx_t   cell_x;
  row_idx_t   cell_y;
  row_t       scan_row;
  logic       row_full;

  assign lock_x[0] = lock_x0;
  assign lock_x[1] = lock_x1;
  assign lock_x[2] = lock_x2;
  assign lock_x[3] = lock_x3;
  assign lock_y[0] = lock_y0;
  assign lock_y[1] = lock_y1;
  assign lock_y[2] = lock_y2;
  assign lock_y[3] = lock_y3;

  // clear_req takes priority; requests outside idle are dropped.
  assign lock_accept = (state_q == StIdle) && lock_start && !clear_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        lat_x_q[i] <= '0;
        lat_y_q[i] <= '0;
      end
      lat_colour_q <= '0;
    end else if (lock_accept) begin
      for (int i = 0; i < 4; i++) begin
        lat_x_q[i] <= lock_x[i];
        lat_y_q[i] <= lock_y[i];
      end
      lat_colour_q <= lock_colour;
    end
  end

  // Cell currently being written; off-board cells are skipped but still cost a cycle.
  always_comb begin
    cell_ok = (lat_x_q[idx_q] < LockXLim) && (lat_y_q[idx_q] < LockYLim);
    cell_x  = lat_x_q[idx_q][COL_IDX_W-1:0];
    cell_y  = lat_y_q[idx_q][ROW_IDX_W-1:0];
  end

  assign scan_row = board_q[row_q];

  board_row_full u_row_full (
    .row  (scan_row),
    .full (row_full)
  );

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    k_d             = k_q;
    idx_d           = idx_q;
    lines_d         = lines_q;
    lines_cleared_d = lines_cleared_q;
    board_d         = board_q;

    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          row_d   = '0;
        end else if (lock_start) begin
          state_d = StWrite;
          idx_d   = '0;
          lines_d = '0;
        end
      end

      StClear: begin
        board_d[row_q] = '0;
        if (row_q == LastRow) begin
          state_d = StIdle;
          row_d   = '0;
        end else begin
          row_d = row_q + RowOne;
        end
      end

      StWrite: begin
        if (cell_ok) begin
          board_d[cell_y][cell_x] = lat_colour_q;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = StScan;
          row_d   = LastRow;
        end
      end

      StScan: begin
        if (row_full) begin
          if (lines_q != MaxLines) begin
            lines_d = lines_q + 3'd1;
          end
          // The detecting edge already performs the first copy (row r from r-1),
          // so a collapse of row r costs r+1 cycles including detection.
          if (row_q == '0) begin
            board_d[0] = '0;
          end else begin
            board_d[row_q] = board_q[row_q - RowOne];
            k_d            = row_q - RowOne;
            state_d        = StShift;
          end
        end else if (row_q == '0) begin
          state_d         = StDone;
          lines_cleared_d = lines_q;
        end else begin
          row_d = row_q - RowOne;
        end
      end

      StShift: begin
        if (k_q != '0) begin
          board_d[k_q] = board_q[k_q - RowOne];
          k_d          = k_q - RowOne;
        end else begin
          // Row index is left unchanged so the row shifted into it is rechecked.
          board_d[0] = '0;
          state_d    = StScan;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      row_q           <= '0;
      k_q             <= '0;
      idx_q           <= '0;
      lines_q         <= '0;
      lines_cleared_q <= '0;
      for (int r = 0; r < BOARD_H; r++) begin
        board_q[r] <= '0;
      end
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      k_q             <= k_d;
      idx_q           <= idx_d;
      lines_q         <= lines_d;
      lines_cleared_q <= lines_cleared_d;
      board_q         <= board_d;
    end
  end

  assign board_rdy     = (state_q == StIdle);
  assign lock_done     = (state_q == StDone);
  assign lines_cleared = lines_cleared_q;

  always_comb begin
    query_occupied = 1'b1;
    if ((query_x < ColLim) && (query_y < RowLim)) begin
      query_occupied = |board_q[query_y][query_x];
    end
    vga_colour = '0;
    if ((vga_x < ColLim) && (vga_y < RowLim)) begin
      vga_colour = board_q[vga_y][vga_x];
    end
  end

  assign vga_occupied = |vga_colour;

endmodule

// File: tb/tb_playfield_lock_clear.sv
// Scoreboard bench for playfield_lock_clear: each lock pushes the expected
// line count and latency from a reference board model; the entry is popped
// and compared when lock_done arrives, then the whole board is swept.
module tb_playfield_lock_clear;
  import tetris_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clear_req = 1'b0;
  logic                board_rdy;
  logic                lock_start = 1'b0;
  logic [5:0]          lock_x0 = '0, lock_x1 = '0, lock_x2 = '0, lock_x3 = '0;
  logic [5:0]          lock_y0 = '0, lock_y1 = '0, lock_y2 = '0, lock_y3 = '0;
  logic [COLOUR_W-1:0] lock_colour = '0;
  logic                lock_done;
  logic [2:0]          lines_cleared;
  logic [3:0]          query_x = '0;
  logic [4:0]          query_y = '0;
  logic                query_occupied;
  logic [3:0]          vga_x = '0;
  logic [4:0]          vga_y = '0;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_occupied;

  always #5 clk = ~clk;

  playfield_lock_clear dut (
    .clk            (clk),
    .rst            (rst),
    .clear_req      (clear_req),
    .board_rdy      (board_rdy),
    .lock_start     (lock_start),
    .lock_x0        (lock_x0),
    .lock_x1        (lock_x1),
    .lock_x2        (lock_x2),
    .lock_x3        (lock_x3),
    .lock_y0        (lock_y0),
    .lock_y1        (lock_y1),
    .lock_y2        (lock_y2),
    .lock_y3        (lock_y3),
    .lock_colour    (lock_colour),
    .lock_done      (lock_done),
    .lines_cleared  (lines_cleared),
    .query_x        (query_x),
    .query_y        (query_y),
    .query_occupied (query_occupied),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_occupied   (vga_occupied)
  );

  typedef struct packed {
    int lines;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   mdl [BOARD_H][BOARD_W];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic do_lock(input int x0, input int x1, input int x2, input int x3,
                         input int y0, input int y1, input int y2, input int y3,
                         input int colour, input int inject_at);
    int   xs[4];
    int   ys[4];
    int   n;
    int   cycles;
    int   lines;
    int   exp_lat;
    int   r;
    bit   full;
    int   bad;
    int   extra;
    exp_t e;
    xs = '{x0, x1, x2, x3};
    ys = '{y0, y1, y2, y3};
    @(negedge clk);
    n = 0;
    while (board_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (board_rdy !== 1'b1) $display("FAIL rdy_wait: board_rdy=%b required 1", board_rdy);
    else n_pass++;
    lock_x0 = 6'(x0); lock_x1 = 6'(x1); lock_x2 = 6'(x2); lock_x3 = 6'(x3);
    lock_y0 = 6'(y0); lock_y1 = 6'(y1); lock_y2 = 6'(y2); lock_y3 = 6'(y3);
    lock_colour = 3'(colour);
    lock_start = 1'b1;
    // Reference model: write, then bottom-up collapse with recheck.
    for (int i = 0; i < 4; i++) begin
      if (xs[i] < int'(BOARD_W) && ys[i] < int'(BOARD_H)) mdl[ys[i]][xs[i]] = colour;
    end
    lines = 0;
    exp_lat = 4 + int'(BOARD_H);
    r = int'(BOARD_H) - 1;
    while (r >= 0) begin
      full = 1'b1;
      for (int c = 0; c < int'(BOARD_W); c++) if (mdl[r][c] == 0) full = 1'b0;
      if (full) begin
        if (lines < 4) lines++;
        exp_lat += r + 1;
        for (int rr = r; rr > 0; rr--)
          for (int c = 0; c < int'(BOARD_W); c++) mdl[rr][c] = mdl[rr-1][c];
        for (int c = 0; c < int'(BOARD_W); c++) mdl[0][c] = 0;
      end else begin
        r--;
      end
    end
    e.lines = lines;
    e.lat = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    lock_start = 1'b0;
    cycles = 0;
    while (lock_done !== 1'b1 && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == inject_at) begin
        lock_x0 = 6'd5; lock_x1 = 6'd6; lock_x2 = 6'd7; lock_x3 = 6'd8;
        lock_y0 = 6'd2; lock_y1 = 6'd2; lock_y2 = 6'd2; lock_y3 = 6'd2;
        lock_start = 1'b1;
      end else begin
        lock_start = 1'b0;
      end
    end
    lock_start = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (lock_done !== 1'b1 || cycles != e.lat)
      $display("FAIL latency: lock_done=%b after %0d cycles, required 1 after %0d",
               lock_done, cycles, e.lat);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 3'(e.lines))
      $display("FAIL lines_cleared: got %0d required %0d", lines_cleared, e.lines);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (lock_done !== 1'b0) $display("FAIL done_width: lock_done=%b required 0", lock_done);
    else n_pass++;
    if (inject_at >= 0) begin
      extra = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (lock_done === 1'b1) extra++;
      end
      n_checks++;
      if (extra != 0) $display("FAIL extra_done: %0d extra pulses, required 0", extra);
      else n_pass++;
    end
    bad = 0;
    for (int y = 0; y < int'(BOARD_H); y++) begin
      for (int x = 0; x < int'(BOARD_W); x++) begin
        vga_x = 4'(x); vga_y = 5'(y); query_x = 4'(x); query_y = 5'(y);
        #1;
        if (vga_colour !== 3'(mdl[y][x]) || vga_occupied !== (mdl[y][x] != 0) ||
            query_occupied !== (mdl[y][x] != 0)) bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL board: %0d cells differ, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (board_rdy !== 1'b1) $display("FAIL reset_rdy: got %b required 1", board_rdy);
    else n_pass++;
    n_checks++;
    if (lock_done !== 1'b0) $display("FAIL reset_done: got %b required 0", lock_done);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 3'd0) $display("FAIL reset_lines: got %0d required 0", lines_cleared);
    else n_pass++;
    bad = 0;
    for (int y = 0; y < int'(BOARD_H); y++) begin
      for (int x = 0; x < int'(BOARD_W); x++) begin
        mdl[y][x] = 0;
        vga_x = 4'(x); vga_y = 5'(y);
        #1;
        if (vga_colour !== 3'd0) bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_board: %0d cells non-zero, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic_lock();
    do_lock(0, 1, 2, 3, 19, 19, 19, 19, 3, -1);
    query_x = 4'd2; query_y = 5'd19; vga_x = 4'd3; vga_y = 5'd19;
    #1;
    n_checks++;
    if (query_occupied !== 1'b1) $display("FAIL query_2_19: got %b required 1", query_occupied);
    else n_pass++;
    n_checks++;
    if (vga_colour !== 3'd3) $display("FAIL vga_3_19: got %0d required 3", vga_colour);
    else n_pass++;
    query_x = 4'd4;
    #1;
    n_checks++;
    if (query_occupied !== 1'b0) $display("FAIL query_4_19: got %b required 0", query_occupied);
    else n_pass++;
  endtask

  task automatic test_single_clear();
    // Cols 4,5 of row 19; the two off-board (y>=20) cells are skipped.
    do_lock(4, 5, 4, 5, 19, 19, 25, 30, 6, -1);
    do_lock(6, 7, 8, 9, 19, 19, 19, 19, 5, -1);
    vga_x = 4'd0; vga_y = 5'd19;
    #1;
    n_checks++;
    if (vga_colour !== 3'd0) $display("FAIL row19_after_clear: got %0d required 0", vga_colour);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    query_x = 4'd10; query_y = 5'd0;
    #1;
    n_checks++;
    if (query_occupied !== 1'b1) $display("FAIL query_x10: got %b required 1", query_occupied);
    else n_pass++;
    query_x = 4'd3; query_y = 5'd20;
    #1;
    n_checks++;
    if (query_occupied !== 1'b1) $display("FAIL query_y20: got %b required 1", query_occupied);
    else n_pass++;
    vga_x = 4'd12; vga_y = 5'd0;
    #1;
    n_checks++;
    if (vga_colour !== 3'd0 || vga_occupied !== 1'b0)
      $display("FAIL vga_x12: colour=%0d occ=%b required 0/0", vga_colour, vga_occupied);
    else n_pass++;
    do_lock(15, 0, 1, 2, 5, 5, 5, 5, 2, -1);
    query_x = 4'd0; query_y = 5'd5;
    #1;
    n_checks++;
    if (query_occupied !== 1'b1) $display("FAIL query_0_5: got %b required 1", query_occupied);
    else n_pass++;
  endtask

  task automatic test_ignore_during_scan();
    do_lock(0, 1, 2, 3, 0, 0, 0, 0, 1, 10);
  endtask

  task automatic test_clear_priority();
    int n;
    int low;
    int done_seen;
    int bad;
    @(negedge clk);
    n = 0;
    while (board_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    clear_req = 1'b1;
    lock_start = 1'b1;
    lock_x0 = 6'd0; lock_x1 = 6'd1; lock_x2 = 6'd2; lock_x3 = 6'd3;
    lock_y0 = 6'd10; lock_y1 = 6'd10; lock_y2 = 6'd10; lock_y3 = 6'd10;
    lock_colour = 3'd7;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    lock_start = 1'b0;
    low = 0;
    done_seen = 0;
    while (board_rdy !== 1'b1 && low < 100) begin
      low++;
      if (lock_done === 1'b1) done_seen++;
      @(posedge clk);
      #1;
    end
    repeat (30) begin
      @(posedge clk);
      #1;
      if (lock_done === 1'b1) done_seen++;
    end
    n_checks++;
    if (low != 20) $display("FAIL clear_busy: board_rdy low %0d cycles required 20", low);
    else n_pass++;
    n_checks++;
    if (done_seen != 0) $display("FAIL clear_no_lock: %0d lock_done pulses required 0", done_seen);
    else n_pass++;
    bad = 0;
    for (int y = 0; y < int'(BOARD_H); y++) begin
      for (int x = 0; x < int'(BOARD_W); x++) begin
        mdl[y][x] = 0;
        vga_x = 4'(x); vga_y = 5'(y);
        #1;
        if (vga_colour !== 3'd0) bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL clear_board: %0d cells non-zero, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_tetris();
    for (int y = 16; y < 20; y++) begin
      do_lock(0, 1, 2, 3, y, y, y, y, 1 + (y % 7), -1);
      do_lock(4, 5, 6, 7, y, y, y, y, 2, -1);
    end
    do_lock(8, 8, 8, 8, 16, 17, 18, 19, 7, -1);
    do_lock(9, 9, 9, 9, 16, 17, 18, 19, 4, -1);
    n_checks++;
    if (lines_cleared !== 3'd4) $display("FAIL tetris_lines: got %0d required 4", lines_cleared);
    else n_pass++;
  endtask

  task automatic test_reset_during_shift();
    int n;
    int cycles;
    int bad;
    int done_seen;
    do_lock(0, 1, 2, 3, 19, 19, 19, 19, 1, -1);
    do_lock(4, 5, 6, 7, 19, 19, 19, 19, 2, -1);
    do_lock(0, 1, 2, 3, 18, 18, 18, 18, 3, -1);
    do_lock(4, 5, 6, 7, 18, 18, 18, 18, 4, -1);
    do_lock(8, 9, 8, 9, 19, 19, 17, 17, 5, -1);
    @(negedge clk);
    n = 0;
    while (board_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    lock_x0 = 6'd8; lock_x1 = 6'd9; lock_x2 = 6'd0; lock_x3 = 6'd1;
    lock_y0 = 6'd19; lock_y1 = 6'd19; lock_y2 = 6'd17; lock_y3 = 6'd17;
    lock_colour = 3'd6;
    lock_start = 1'b1;
    @(posedge clk);
    #1;
    lock_start = 1'b0;
    cycles = 0;
    while (cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    n_checks++;
    if (board_rdy !== 1'b0 || lines_cleared !== 3'd1)
      $display("FAIL pre_reset: rdy=%b lines=%0d required 0/1", board_rdy, lines_cleared);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (board_rdy !== 1'b1) $display("FAIL abort_rdy: got %b required 1", board_rdy);
    else n_pass++;
    n_checks++;
    if (lock_done !== 1'b0) $display("FAIL abort_done: got %b required 0", lock_done);
    else n_pass++;
    n_checks++;
    if (lines_cleared !== 3'd0) $display("FAIL abort_lines: got %0d required 0", lines_cleared);
    else n_pass++;
    bad = 0;
    for (int y = 0; y < int'(BOARD_H); y++) begin
      for (int x = 0; x < int'(BOARD_W); x++) begin
        mdl[y][x] = 0;
        vga_x = 4'(x); vga_y = 5'(y);
        #1;
        if (vga_colour !== 3'd0) bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_board: %0d cells non-zero, required 0", bad);
    else n_pass++;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (lock_done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL abort_no_done: %0d pulses required 0", done_seen);
    else n_pass++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_lock();
    test_single_clear();
    test_out_of_range();
    test_ignore_during_scan();
    test_clear_priority();
    test_tetris();
    test_reset_during_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
